// File: rtl/fp32_align_unpack.sv
// FP32 add-path front end: unpacks two operands, orders them by exponent
// and right-aligns the smaller mantissa over several cycles.
module fp32_align_unpack #(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] man_big,
  output logic [23:0] man_small,
  output logic        sign_big,
  output logic        sign_small,
  output logic [7:0]  exp_base,
  output logic        sticky,
  output logic        special
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALIGN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_rem;

  logic [7:0]  w_exp_a;
  logic [7:0]  w_exp_b;
  logic [23:0] w_man_a;
  logic [23:0] w_man_b;
  logic        w_a_big;
  logic [7:0]  w_exp_big;
  logic [7:0]  w_diff;
  logic [23:0] w_man_sm;
  logic        w_special;
  logic        w_accept;
  logic [4:0]  w_step;
  logic [23:0] w_mask;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid && in_ready;

  assign w_exp_a   = op_a[30:23];
  assign w_exp_b   = op_b[30:23];
  // Exponent 0 flushes the whole mantissa, so denormals never align.
  assign w_man_a   = (w_exp_a != 8'd0) ? {1'b1, op_a[22:0]} : 24'd0;
  assign w_man_b   = (w_exp_b != 8'd0) ? {1'b1, op_b[22:0]} : 24'd0;
  assign w_a_big   = (w_exp_a >= w_exp_b);
  assign w_exp_big = w_a_big ? w_exp_a : w_exp_b;
  assign w_diff    = w_a_big ? (w_exp_a - w_exp_b) : (w_exp_b - w_exp_a);
  assign w_man_sm  = w_a_big ? w_man_b : w_man_a;
  assign w_special = (w_exp_a == 8'hFF) || (w_exp_b == 8'hFF);

  assign w_step = (r_rem > STEP) ? STEP : r_rem;
  assign w_mask = (24'd1 << w_step) - 24'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = w_accept ? S_ALIGN : S_IDLE;
      S_ALIGN: w_next = (r_rem == 5'd0) ? S_DONE : S_ALIGN;
      S_DONE:  w_next = out_ready ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem      <= 5'd0;
      man_big    <= 24'd0;
      man_small  <= 24'd0;
      sign_big   <= 1'b0;
      sign_small <= 1'b0;
      exp_base   <= 8'd0;
      sticky     <= 1'b0;
      special    <= 1'b0;
    end else if (w_accept) begin
      man_big    <= w_a_big ? w_man_a : w_man_b;
      sign_big   <= w_a_big ? op_a[31] : op_b[31];
      sign_small <= w_a_big ? op_b[31] : op_a[31];
      exp_base   <= w_exp_big;
      special    <= w_special;
      if (w_special || w_diff == 8'd0) begin
        man_small <= w_man_sm;
        sticky    <= 1'b0;
        r_rem     <= 5'd0;
      end else if (w_diff >= 8'd24) begin
        man_small <= 24'd0;
        sticky    <= |w_man_sm;
        r_rem     <= 5'd0;
      end else begin
        man_small <= w_man_sm;
        sticky    <= 1'b0;
        r_rem     <= w_diff[4:0];
      end
    end else if (r_state == S_ALIGN && r_rem != 5'd0) begin
      man_small <= man_small >> w_step;
      sticky    <= sticky | (|(man_small & w_mask));
      r_rem     <= r_rem - w_step;
    end
  end

endmodule

// File: tb/tb_fp32_align_unpack.sv
// Directed bench for fp32_align_unpack; runs STEP 1, 2 and 4 side by side
// on shared inputs and checks data and latency of each.
module tb_fp32_align_unpack;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;

  logic        ir[3];
  logic        ov[3];
  logic        sb[3];
  logic        ss[3];
  logic        st[3];
  logic        sp[3];
  logic [23:0] mb[3];
  logic [23:0] ms[3];
  logic [7:0]  eb[3];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp32_align_unpack #(.SHIFT_STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
    .op_a(op_a), .op_b(op_b), .out_valid(ov[0]), .out_ready(out_ready),
    .man_big(mb[0]), .man_small(ms[0]), .sign_big(sb[0]),
    .sign_small(ss[0]), .exp_base(eb[0]), .sticky(st[0]), .special(sp[0])
  );

  fp32_align_unpack #(.SHIFT_STEP(2)) u_s2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
    .op_a(op_a), .op_b(op_b), .out_valid(ov[1]), .out_ready(out_ready),
    .man_big(mb[1]), .man_small(ms[1]), .sign_big(sb[1]),
    .sign_small(ss[1]), .exp_base(eb[1]), .sticky(st[1]), .special(sp[1])
  );

  fp32_align_unpack #(.SHIFT_STEP(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
    .op_a(op_a), .op_b(op_b), .out_valid(ov[2]), .out_ready(out_ready),
    .man_big(mb[2]), .man_small(ms[2]), .sign_big(sb[2]),
    .sign_small(ss[2]), .exp_base(eb[2]), .sticky(st[2]), .special(sp[2])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [23:0] emb, input logic [23:0] ems,
                        input logic esb, input logic ess,
                        input logic [7:0] eeb, input logic est,
                        input logic esp,
                        input int l1, input int l2, input int l4);
    int lat[3];
    int lexp[3];
    lexp = '{l1, l2, l4};
    lat  = '{0, 0, 0};
    @(negedge clk);
    chk({tag, ":rdy"}, 32'(ir[0]), 32'd1);
    op_a = a;
    op_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a = ~a;
    op_b = ~b;
    for (int n = 1; n <= 40; n++) begin
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++)
        if (ov[k] && lat[k] == 0) lat[k] = n;
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s:lat%0d", tag, k), 32'(lat[k]), 32'(lexp[k]));
      chk($sformatf("%s:ms%0d", tag, k), 32'(ms[k]), 32'(ems));
      chk($sformatf("%s:st%0d", tag, k), 32'(st[k]), 32'(est));
    end
    chk({tag, ":mb"}, 32'(mb[0]), 32'(emb));
    chk({tag, ":sb"}, 32'(sb[0]), 32'(esb));
    chk({tag, ":ss"}, 32'(ss[0]), 32'(ess));
    chk({tag, ":eb"}, 32'(eb[0]), 32'(eeb));
    chk({tag, ":sp"}, 32'(sp[0]), 32'(esp));
    chk({tag, ":busy"}, 32'(ir[0]), 32'd0);
  endtask

  task automatic release_op(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ":ov_drop"}, 32'(ov[0]), 32'd0);
    chk({tag, ":rdy_back"}, 32'(ir[0]), 32'd1);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst:ov", 32'(ov[0]), 32'd0);
    chk("rst:rdy", 32'(ir[0]), 32'd1);
    chk("rst:mb", 32'(mb[0]), 32'd0);
    chk("rst:ms", 32'(ms[0]), 32'd0);
    chk("rst:eb", 32'(eb[0]), 32'd0);
    chk("rst:st", 32'(st[0]), 32'd0);
    chk("rst:sp", 32'(sp[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("one", 32'h3F800000, 32'h3F800000, 24'h800000, 24'h800000,
           1'b0, 1'b0, 8'd127, 1'b0, 1'b0, 1, 1, 1);
    release_op("one");

    run_op("d3", 32'h3FC00001, 32'h41000000, 24'h800000, 24'h180000,
           1'b0, 1'b0, 8'd130, 1'b1, 1'b0, 4, 3, 2);
    release_op("d3");

    run_op("d30", 32'h4E800000, 32'hBF800000, 24'h800000, 24'h000000,
           1'b0, 1'b1, 8'd157, 1'b1, 1'b0, 1, 1, 1);
    release_op("d30");

    run_op("tie", 32'hBF800000, 32'h3F800000, 24'h800000, 24'h800000,
           1'b1, 1'b0, 8'd127, 1'b0, 1'b0, 1, 1, 1);
    release_op("tie");

    run_op("d24", 32'h4B800000, 32'h3F800001, 24'h800000, 24'h000000,
           1'b0, 1'b0, 8'd151, 1'b1, 1'b0, 1, 1, 1);
    release_op("d24");

    run_op("d23", 32'h4B000000, 32'h3F800001, 24'h800000, 24'h000001,
           1'b0, 1'b0, 8'd150, 1'b1, 1'b0, 24, 13, 7);
    release_op("d23");

    run_op("dnrm", 32'h3F800000, 32'h00400000, 24'h800000, 24'h000000,
           1'b0, 1'b0, 8'd127, 1'b0, 1'b0, 1, 1, 1);
    release_op("dnrm");

    run_op("inf", 32'h7F800000, 32'h3F800000, 24'h800000, 24'h800000,
           1'b0, 1'b0, 8'd255, 1'b0, 1'b1, 1, 1, 1);
    in_valid = 1'b1;
    op_a = 32'h40000000;
    op_b = 32'h3F800000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d:ov", i), 32'(ov[0]), 32'd1);
      chk($sformatf("hold%0d:rdy", i), 32'(ir[0]), 32'd0);
      chk($sformatf("hold%0d:eb", i), 32'(eb[0]), 32'd255);
      chk($sformatf("hold%0d:ms", i), 32'(ms[0]), 32'h800000);
      chk($sformatf("hold%0d:sp", i), 32'(sp[0]), 32'd1);
    end
    in_valid = 1'b0;
    release_op("inf");
    chk("inf:keep_eb", 32'(eb[0]), 32'd255);

    @(negedge clk);
    op_a = 32'h49800000;
    op_b = 32'h3F800000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort:ov", 32'(ov[0]), 32'd0);
    chk("abort:rdy", 32'(ir[0]), 32'd1);
    chk("abort:mb", 32'(mb[0]), 32'd0);
    chk("abort:ms", 32'(ms[0]), 32'd0);
    chk("abort:eb", 32'(eb[0]), 32'd0);
    chk("abort:st", 32'(st[0]), 32'd0);
    chk("abort:sb", 32'(sb[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("post", 32'h3F800000, 32'h3F800000, 24'h800000, 24'h800000,
           1'b0, 1'b0, 8'd127, 1'b0, 1'b0, 1, 1, 1);
    release_op("post");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
